// File: rtl/rc5_block_engine.sv
// rc5_block_engine: parametrised RC5-W/R/B core with on-chip key load, key schedule FSM and an
// iterative block cipher running one full round per clock behind valid/ready handshakes.
// Define RC5_DECRYPT_EN to build the decrypt datapath; otherwise iMode is ignored and every
// block is encrypted.
module rc5_block_engine #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16,
  parameter logic [W-1:0] P = 32'hB7E15163,
  parameter logic [W-1:0] Q = 32'h9E3779B9,
  localparam int KAW = (B > 1) ? $clog2(B) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           iKeyWe,
  input  logic [KAW-1:0] iKeyAddr,
  input  logic [7:0]     iKeyByte,
  input  logic           iKeyStart,
  output logic           oKeyReady,
  input  logic           iValid,
  output logic           oReady,
  input  logic           iMode,
  input  logic [W-1:0]   iA,
  input  logic [W-1:0]   iB,
  output logic           oValid,
  input  logic           iReady,
  output logic [W-1:0]   oA,
  output logic [W-1:0]   oB
);

  localparam int T    = 2 * (R + 1);
  localparam int U    = W / 8;
  localparam int C    = (B + U - 1) / U;
  localparam int MIXN = 3 * ((T > C) ? T : C);
  localparam int LGW  = $clog2(W);
  localparam int TW   = $clog2(T);
  localparam int CW   = (C > 1) ? $clog2(C) : 1;
  localparam int NW   = $clog2(MIXN);
  localparam int RW   = $clog2(R + 2);
  localparam int LW   = $clog2(U);

  typedef enum logic [2:0] {IDLE, KINIT, KMIX, READY, CRYPT, OUT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   s [T];
  logic [W-1:0]   l [C];
  logic [W-1:0]   a, b, kval, out_a, out_b;
  logic [TW-1:0]  i, ev_idx, od_idx;
  logic [CW-1:0]  j, key_word;
  logic [LW-1:0]  key_lane;
  logic [NW-1:0]  cnt;
  logic [RW-1:0]  rnd, r_eff;
  logic           key_wr, dec;
  logic [W-1:0]   mix_a, mix_b, round_a, round_b, fin_a, fin_b, load_a, load_b;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

`ifdef RC5_DECRYPT_EN
  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction
`else
  logic unused_mode;
  assign unused_mode = iMode;
  assign dec = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an accepted block wins over a simultaneous iKeyStart in READY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iKeyStart) state_d = KINIT;
      KINIT:   if (i == TW'(T - 1)) state_d = KMIX;
      KMIX:    if (cnt == NW'(MIXN - 1)) state_d = READY;
      READY:   if (iValid) state_d = CRYPT;
               else if (iKeyStart) state_d = KINIT;
      CRYPT:   if (rnd == RW'(R)) state_d = OUT;
      OUT:     if (iReady) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the key stays valid while a block is in flight or waiting in OUT.
  always_comb begin
    oReady    = (state_q == READY);
    oValid    = (state_q == OUT);
    oKeyReady = (state_q == READY) || (state_q == CRYPT) || (state_q == OUT);
  end

  assign oA = out_a;
  assign oB = out_b;

  // Key byte decode (little-endian packing into L words) and round arithmetic.
  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    key_word = CW'(int'(iKeyAddr) / U);
    key_lane = LW'(int'(iKeyAddr) % U);
    key_wr   = iKeyWe && (int'(iKeyAddr) < B) && ((state_q == IDLE) || (state_q == READY));
    r_eff    = rnd;
`ifdef RC5_DECRYPT_EN
    if (dec) r_eff = RW'(R + 1) - rnd;
`endif
    ev_idx  = TW'(2 * int'(r_eff));
    od_idx  = ev_idx + TW'(1);
    mix_a   = rotl(s[i] + a + b, LGW'(3));
    mix_b   = rotl(l[j] + mix_a + b, LGW'(mix_a + b));
    round_a = rotl(a ^ b, LGW'(b)) + s[ev_idx];
    round_b = rotl(b ^ round_a, LGW'(round_a)) + s[od_idx];
    fin_a   = round_a;
    fin_b   = round_b;
    load_a  = iA + s[0];
    load_b  = iB + s[1];
`ifdef RC5_DECRYPT_EN
    if (dec) begin
      round_b = rotr(b - s[od_idx], LGW'(a)) ^ a;
      round_a = rotr(a - s[ev_idx], LGW'(round_b)) ^ round_b;
      fin_a   = round_a - s[0];
      fin_b   = round_b - s[1];
    end
    if (iMode) begin
      load_a = iA;
      load_b = iB;
    end
`endif
  end

  // Datapath: key storage, schedule counters, round registers and the result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: S and L must read as zero after reset, so they are flops with reset, not a RAM.
      for (int k = 0; k < T; k++) s[k] <= '0;
      for (int k = 0; k < C; k++) l[k] <= '0;
      a     <= '0;
      b     <= '0;
      kval  <= '0;
      out_a <= '0;
      out_b <= '0;
      i     <= '0;
      j     <= '0;
      cnt   <= '0;
      rnd   <= '0;
`ifdef RC5_DECRYPT_EN
      dec   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (key_wr) l[key_word][{key_lane, 3'b000} +: 8] <= iKeyByte;
          if (state_d == KINIT) begin
            i    <= '0;
            kval <= P;
          end
          if (state_d == CRYPT) begin
            a   <= load_a;
            b   <= load_b;
            rnd <= RW'(1);
`ifdef RC5_DECRYPT_EN
            dec <= iMode;
`endif
          end
        end
        KINIT: begin
          s[i] <= kval;
          kval <= kval + Q;
          if (i == TW'(T - 1)) begin
            i   <= '0;
            j   <= '0;
            a   <= '0;
            b   <= '0;
            cnt <= '0;
          end else begin
            i <= i + TW'(1);
          end
        end
        KMIX: begin
          s[i] <= mix_a;
          l[j] <= mix_b;
          a    <= mix_a;
          b    <= mix_b;
          i    <= (i == TW'(T - 1)) ? '0 : i + TW'(1);
          j    <= (j == CW'(C - 1)) ? '0 : j + CW'(1);
          cnt  <= cnt + NW'(1);
        end
        CRYPT: begin
          a   <= round_a;
          b   <= round_b;
          rnd <= rnd + RW'(1);
          if (rnd == RW'(R)) begin
            out_a <= fin_a;
            out_b <= fin_b;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_block_engine.sv
// tb_rc5_block_engine: directed RC5-32/12/16 vectors with a result scoreboard. Stimulus pushes
// the expected words; a monitor pops and compares on every oValid && iReady handshake and also
// checks accept-to-oValid latency. Decrypt expectations follow RC5_DECRYPT_EN.
module tb_rc5_block_engine;

  localparam int W = 32;
  localparam int R = 12;
  localparam int B = 16;

  localparam logic [127:0] KEY_ZERO = '0;
  // Bytes 91 5F 46 19 BE 41 B2 51 63 55 A5 01 10 A9 CE 91, byte 0 in the least significant lane.
  localparam logic [127:0] KEY_TWO  = 128'h91CEA910_01A55563_51B241BE_19465F91;

  logic         clk = 1'b0;
  logic         rst;
  logic         iKeyWe, iKeyStart, iValid, iMode, iReady;
  logic [3:0]   iKeyAddr;
  logic [7:0]   iKeyByte;
  logic [W-1:0] iA, iB;
  logic         oKeyReady, oReady, oValid;
  logic [W-1:0] oA, oB;

  rc5_block_engine #(.W(W), .R(R), .B(B)) dut (
    .clk(clk), .rst(rst),
    .iKeyWe(iKeyWe), .iKeyAddr(iKeyAddr), .iKeyByte(iKeyByte), .iKeyStart(iKeyStart),
    .oKeyReady(oKeyReady),
    .iValid(iValid), .oReady(oReady), .iMode(iMode), .iA(iA), .iB(iB),
    .oValid(oValid), .iReady(iReady), .oA(oA), .oB(oB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   accept_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency of each result and scoreboard comparison on every consumed result.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (oReady && iValid) accept_cyc = cyc + 1;
      if (oValid && !prev_valid) check("latency", 64'(cyc - accept_cyc + 1), 64'(R + 1));
      prev_valid = oValid;
      if (oValid && iReady) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got %h %h, want no result", oA, oB);
        end else begin
          popped = sb.pop_front();
          check({popped.name, "_a"}, 64'(oA), 64'(popped.a));
          check({popped.name, "_b"}, 64'(oB), 64'(popped.b));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [127:0] key);
    for (int k = 0; k < 16; k++) begin
      iKeyWe   = 1'b1;
      iKeyAddr = 4'(k);
      iKeyByte = key[8*k +: 8];
      tick();
    end
    iKeyWe = 1'b0;
  endtask

  task automatic start_key(input string name);
    int start;
    int bad;
    int n;
    iKeyStart = 1'b1;
    tick();
    iKeyStart = 1'b0;
    start = cyc;
    bad   = 0;
    n     = 0;
    while (n < 400) begin
      @(negedge clk);
      if (oKeyReady) break;
      if (oReady) bad++;
      n++;
    end
    check({name, "_key_latency"}, 64'(cyc - start), 64'(104));
    check({name, "_ready_low"}, 64'(bad), 64'(0));
    tick();
  endtask

  task automatic send_block(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                            input logic [W-1:0] ea, input logic [W-1:0] eb,
                            input string name, input logic push);
    int n;
    if (push) sb.push_back('{ea, eb, name});
    iA     = a;
    iB     = b;
    iMode  = mode;
    iValid = 1'b1;
    n      = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oReady && n < 500);
    check({name, "_accepted"}, 64'(oReady), 64'(1));
    tick();
    iValid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oReady && n < 500);
    check({name, "_back_to_ready"}, 64'(oReady), 64'(1));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int rdy_bad;
    int n;
    rst = 1'b1; iKeyWe = 1'b0; iKeyAddr = '0; iKeyByte = '0; iKeyStart = 1'b0;
    iValid = 1'b0; iMode = 1'b0; iA = '0; iB = '0; iReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_keyready", 64'(oKeyReady), 64'(0));
    check("reset_ready", 64'(oReady), 64'(0));
    check("reset_valid", 64'(oValid), 64'(0));
    check("reset_oa", 64'(oA), 64'(0));
    check("reset_ob", 64'(oB), 64'(0));
    rst = 1'b0;
    tick();

    // A block offered before any key schedule must not be taken.
    iValid = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (oReady) bad++;
    end
    check("prekey_not_accepted", 64'(bad), 64'(0));
    tick();
    iValid = 1'b0;

    // Vector 1: all-zero key.
    write_key(KEY_ZERO);
    start_key("zero");
    send_block(32'h0, 32'h0, 1'b0, 32'hEEDBA521, 32'h6D8F4B15, "v1_enc", 1'b1);
    wait_ready("v1_enc");
`ifdef RC5_DECRYPT_EN
    send_block(32'hEEDBA521, 32'h6D8F4B15, 1'b1, 32'h0, 32'h0, "v1_dec", 1'b1);
`else
    send_block(32'h0, 32'h0, 1'b1, 32'hEEDBA521, 32'h6D8F4B15, "v1_mode_ignored", 1'b1);
`endif
    wait_ready("v1_mode");

    // Back-pressure: hold iReady low with a second block waiting at the input.
    iReady = 1'b0;
    send_block(32'h0, 32'h0, 1'b0, 32'hEEDBA521, 32'h6D8F4B15, "hold1", 1'b1);
    sb.push_back('{32'hEEDBA521, 32'h6D8F4B15, "hold2"});
    iA = '0; iB = '0; iMode = 1'b0; iValid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oValid && n < 100);
    check("hold_valid_seen", 64'(oValid), 64'(1));
    bad = 0;
    rdy_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!oValid || oA !== 32'hEEDBA521 || oB !== 32'h6D8F4B15) bad++;
      if (oReady) rdy_bad++;
    end
    check("hold_stable", 64'(bad), 64'(0));
    check("hold_second_not_accepted", 64'(rdy_bad), 64'(0));
    tick();
    iReady = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oReady && n < 100);
    check("hold2_accepted", 64'(oReady), 64'(1));
    tick();
    iValid = 1'b0;
    wait_ready("hold2");

    // iKeyStart while a block is in flight is ignored.
    send_block(32'h0, 32'h0, 1'b0, 32'hEEDBA521, 32'h6D8F4B15, "kstart_crypt", 1'b1);
    repeat (2) tick();
    iKeyStart = 1'b1;
    tick();
    iKeyStart = 1'b0;
    wait_ready("kstart_crypt");
    check("kstart_crypt_keyready", 64'(oKeyReady), 64'(1));

    // Rekey from READY with vector 2's key.
    write_key(KEY_TWO);
    start_key("rekey");
    send_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, 32'hAC13C0F7, 32'h52892B5B, "v2_enc", 1'b1);
    wait_ready("v2_enc");
`ifdef RC5_DECRYPT_EN
    send_block(32'hAC13C0F7, 32'h52892B5B, 1'b1, 32'hEEDBA521, 32'h6D8F4B15, "v2_dec", 1'b1);
`else
    send_block(32'hEEDBA521, 32'h6D8F4B15, 1'b1, 32'hAC13C0F7, 32'h52892B5B, "v2_mode_ignored", 1'b1);
`endif
    wait_ready("v2_mode");

    // Asynchronous reset in the middle of CRYPT drops the block and the key.
    send_block(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0, 32'h0, "aborted", 1'b0);
    repeat (4) tick();
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(oValid), 64'(0));
    check("midrst_keyready", 64'(oKeyReady), 64'(0));
    check("midrst_oa", 64'(oA), 64'(0));
    check("midrst_ob", 64'(oB), 64'(0));
    tick();
    rst = 1'b0;
    iValid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (oReady) bad++;
    end
    check("postrst_not_accepted", 64'(bad), 64'(0));
    tick();
    iValid = 1'b0;
    write_key(KEY_TWO);
    start_key("postrst");
    send_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, 32'hAC13C0F7, 32'h52892B5B, "postrst_enc", 1'b1);
    wait_ready("postrst_enc");

    repeat (5) tick();
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
